dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit words in the internal storage array (power of two, 4..65536).
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the request-accept-to-response delay in cycles (legal range 1..7).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port req_valid_i, input, 1 bit: the initiator presents a request.
REQ-006 The block SHALL have port req_ready_o, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port req_addr_i, input, 32 bits: byte address.
REQ-008 The block SHALL have port req_we_i, input, 1 bit: 1 = store, 0 = load.
REQ-009 The block SHALL have port req_size_i, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-010 The block SHALL have port req_unsigned_i, input, 1 bit: 1 = zero-extend load data, 0 = sign-extend.
REQ-011 The block SHALL have port req_wdata_i, input, 32 bits: store data, right-aligned (bits [7:0] for byte, [15:0] for half).
REQ-012 The block SHALL have port rsp_valid_o, output, 1 bit: a response is presented.
REQ-013 The block SHALL have port rsp_ready_i, input, 1 bit: the initiator accepts the response.
REQ-014 The block SHALL have port rsp_rdata_o, output, 32 bits: extended load data; 0 for stores and errors.
REQ-015 The block SHALL have port rsp_err_o, output, 1 bit: the request was rejected (misaligned, out of range, or illegal size).

Function
REQ-016 The FSM SHALL have three states, IDLE, WAIT and RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on a rising edge with req_valid_i=1 and req_ready_o=1; all req_* fields SHALL be registered at that edge and ignored afterwards.
REQ-018 On accept, the FSM SHALL go to WAIT and load a latency counter; rsp_valid_o SHALL rise exactly LATENCY edges after the accept edge (LATENCY=1: one edge later).
REQ-019 On the edge that enters RESP, the block SHALL perform the memory operation: store write, or load read and data registration.
REQ-020 In RESP, rsp_valid_o, rsp_rdata_o and rsp_err_o SHALL be held stable until a rising edge with rsp_ready_i=1, which SHALL return the FSM to IDLE.
REQ-021 Only one request SHALL be outstanding at a time; req_ready_o SHALL be 0 in the cycle of the response handshake, so the next accept is possible at the earliest one edge after that handshake.
REQ-022 Word index SHALL be req_addr_i[31:2]; the byte lane SHALL be req_addr_i[1:0]; storage SHALL be little-endian.
REQ-023 The block SHALL flag an error if size=11, if size=01 and addr[0]=1, if size=10 and addr[1:0]!=00, or if addr[31:2] >= DEPTH_WORDS.
REQ-024 An errored store SHALL NOT modify storage; an errored load SHALL return rdata 0; an errored request SHALL still take LATENCY cycles and complete the handshake.
REQ-025 Stores SHALL modify only the addressed lanes: byte uses lane addr[1:0], half uses lanes addr[1]*2 and +1, word uses all four lanes.
REQ-026 Loads SHALL shift the addressed lane(s) to bit 0, then sign- or zero-extend per req_unsigned_i; for a word load, req_unsigned_i SHALL have no effect.
REQ-027 A load issued after a completed store to the same address SHALL return the stored data.

Reset
REQ-028 When rst_ni=0, the block SHALL immediately force state=IDLE, counter=0, rsp_valid_o=0, rsp_rdata_o=0 and rsp_err_o=0; req_ready_o SHALL be 1 from the first edge after rst_ni is released.
REQ-029 Reset SHALL NOT clear the storage array.
REQ-030 Reset asserted in WAIT SHALL abort the request without performing its store; reset asserted in RESP SHALL discard the response, and a store already performed SHALL persist.

Verification
REQ-031 With LATENCY=2: store word 0x0000_0010 <- 0xDEADBEEF, then load word 0x10 -> rsp_valid_o high 2 edges after each accept, rdata=0xDEADBEEF, err=0.
REQ-032 Store byte 0x11 <- 0x80 over 0xDEADBEEF -> word becomes 0xDEAD80EF; load byte signed 0x11 -> 0xFFFFFF80; load byte unsigned 0x11 -> 0x00000080.
REQ-033 Load half 0x13, store word 0x12, and load word at address DEPTH_WORDS*4 -> each returns err=1 and rdata=0; the word at 0x10 is unchanged.
REQ-034 Hold rsp_ready_i=0 for 5 cycles in RESP -> rsp_valid_o/rdata/err stable, req_ready_o=0, and a new req_valid_i is ignored; after rsp_ready_i=1 the next accept occurs 1 edge later.
REQ-035 Assert rst_ni=0 one cycle after accepting store word 0x20 <- 0x12345678 -> outputs reset immediately; a later load of 0x20 returns the previous contents, not 0x12345678.
REQ-036 Run with LATENCY=1 and with LATENCY=7 -> rsp_valid_o rises exactly 1 and 7 edges after accept, respectively.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data memory responder with fixed latency
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  request handshake (ready only in IDLE)
//   req_addr_i               byte address (word index [31:2], lane [1:0])
//   req_we_i                 1 = store, 0 = load
//   req_size_i               00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i           1 = zero-extend load data, 0 = sign-extend
//   req_wdata_i              right-aligned store data
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_rdata_o              extended load data (0 for stores and errors)
//   rsp_err_o                request rejected (misaligned, out of range, illegal size)

module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          op_now;
  logic          err;
  logic          out_of_range;
  logic [31:0]   word_addr;
  logic [1:0]    lane;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   load_val;
  logic [3:0]    be;
  logic [31:0]   wd_al;

  assign accept  = req_valid_i && (state_q == IDLE);
  // The memory operation happens on the edge that leaves WAIT for RESP.
  assign op_now  = (state_q == WAIT) && (cnt_q == 3'd0);

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  assign word_addr    = {2'b00, addr_q[31:2]};
  assign out_of_range = (word_addr >= 32'(DEPTH_WORDS));
  assign lane         = addr_q[1:0];
  // Only meaningful when in range; truncation is harmless because err gates use.
  assign idx          = addr_q[AW+1:2];

  always_comb begin
    err = out_of_range;
    case (size_q)
      2'b01:   if (addr_q[0]) err = 1'b1;
      2'b10:   if (addr_q[1:0] != 2'b00) err = 1'b1;
      2'b11:   err = 1'b1;
      default: ;
    endcase
  end

  assign rd_word  = mem[idx];
  assign rd_shift = rd_word >> {lane, 3'b000};

  always_comb begin
    load_val = rd_word;
    case (size_q)
      2'b00:   load_val = uns_q ? {24'h0, rd_shift[7:0]}
                                : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_val = uns_q ? {16'h0, rd_shift[15:0]}
                                : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: load_val = rd_word;
    endcase
  end

  // Replicate store data across lanes so each byte enable picks its own copy.
  always_comb begin
    be    = 4'b1111;
    wd_al = wdata_q;
    case (size_q)
      2'b00: begin
        be    = 4'b0001 << lane;
        wd_al = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wd_al = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = WAIT;
      WAIT:    if (cnt_q == 3'd0) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= 3'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q   <= 3'(LATENCY - 1);
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        we_q    <= req_we_i;
        uns_q   <= req_unsigned_i;
        size_q  <= req_size_i;
      end else if (state_q == WAIT && cnt_q != 3'd0) begin
        cnt_q <= cnt_q - 3'd1;
      end
      if (op_now) begin
        rdata_q <= (err || we_q) ? 32'h0 : load_val;
        err_q   <= err;
      end else if (state_q == RESP && rsp_ready_i) begin
        rdata_q <= 32'h0;
        err_q   <= 1'b0;
      end
    end
  end

  // Storage has no reset; reset forces IDLE asynchronously, so op_now is low.
  always_ff @(posedge clk_i) begin
    if (op_now && we_q && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd_al[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder

module tb_dmem_responder;

  localparam int LAT = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_uns = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        x_valid = 1'b0;
  logic        x_rsp_ready = 1'b1;
  logic        r1, v1, e1b, r7, v7, e7b;
  logic [31:0] d1, d7;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_we_i(req_we), .req_size_i(req_size),
    .req_unsigned_i(req_uns), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_lat1 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(x_valid), .req_ready_o(r1),
    .req_addr_i(req_addr), .req_we_i(req_we), .req_size_i(req_size),
    .req_unsigned_i(req_uns), .req_wdata_i(req_wdata),
    .rsp_valid_o(v1), .rsp_ready_i(x_rsp_ready),
    .rsp_rdata_o(d1), .rsp_err_o(e1b)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(7)) u_lat7 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(x_valid), .req_ready_o(r7),
    .req_addr_i(req_addr), .req_we_i(req_we), .req_size_i(req_size),
    .req_unsigned_i(req_uns), .req_wdata_i(req_wdata),
    .rsp_valid_o(v7), .rsp_ready_i(x_rsp_ready),
    .rsp_rdata_o(d7), .rsp_err_o(e7b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: compares every presented response cycle against the queue head.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        if (!prev_valid) chk("latency", 32'(cyc - sb[0].acc), 32'(LAT));
        chk("rdata", rsp_rdata, sb[0].rdata);
        chk("err", {31'h0, rsp_err}, {31'h0, sb[0].err});
        if (rsp_ready) void'(sb.pop_front());
      end
    end
    prev_valid = rsp_valid;
  end

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    req_we = we; req_size = sz; req_uns = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
  endtask

  // Drives a request at a negedge and returns #1 after the accept edge.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, output bit ok);
    int n = 0;
    @(negedge clk);
    drive(we, sz, uns, a, wd);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    ok = req_ready;
    if (!ok) begin
      chk("accept_timeout", 32'd1, 32'd0);
      req_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
    bit ok;
    issue(we, sz, uns, a, wd, ok);
    if (ok) begin
      sb.push_back('{rdata: exp_rd, err: exp_err, acc: cyc});
      req_valid = 1'b0;
      drain();
    end
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    if (!rsp_valid) chk(nm, 32'd0, 32'd1);
  endtask

  initial begin
    bit ok;
    int lat1, lat7;
    #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", {31'h0, rsp_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic word, byte and half traffic.
    do_req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    do_req(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    do_req(1, 2'b00, 0, 32'h11, 32'h00000080, 32'h0, 0);
    do_req(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD80EF, 0);
    do_req(0, 2'b00, 0, 32'h11, 32'h0, 32'hFFFFFF80, 0);
    do_req(0, 2'b00, 1, 32'h11, 32'h0, 32'h00000080, 0);
    do_req(0, 2'b00, 0, 32'h10, 32'h0, 32'hFFFFFFEF, 0);
    do_req(0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFFDEAD, 0);
    do_req(0, 2'b01, 1, 32'h10, 32'h0, 32'h000080EF, 0);

    // Error cases: misaligned, out of range, illegal size.
    do_req(0, 2'b01, 0, 32'h13, 32'h0, 32'h0, 1);
    do_req(1, 2'b10, 0, 32'h12, 32'h55555555, 32'h0, 1);
    do_req(0, 2'b10, 0, 32'h400, 32'h0, 32'h0, 1);
    do_req(1, 2'b10, 0, 32'h400, 32'h66666666, 32'h0, 1);
    do_req(1, 2'b11, 0, 32'h10, 32'h77777777, 32'h0, 1);
    do_req(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD80EF, 0);

    // Half store into upper lanes; unsigned flag ignored for word loads.
    do_req(1, 2'b01, 0, 32'h12, 32'hAAAA1234, 32'h0, 0);
    do_req(0, 2'b10, 1, 32'h10, 32'h0, 32'h123480EF, 0);

    // Backpressure: response held, a new request is ignored until after the handshake.
    rsp_ready = 1'b0;
    issue(0, 2'b10, 0, 32'h10, 32'h0, ok);
    if (ok) begin
      sb.push_back('{rdata: 32'h123480EF, err: 1'b0, acc: cyc});
      drive(0, 2'b00, 1, 32'h13, 32'h0);
      wait_valid("hold_valid_timeout");
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("hold_req_ready", {31'h0, req_ready}, 32'd0);
        chk("hold_rsp_valid", {31'h0, rsp_valid}, 32'd1);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("hs_rsp_valid", {31'h0, rsp_valid}, 32'd0);
      chk("hs_req_ready", {31'h0, req_ready}, 32'd1);
      sb.push_back('{rdata: 32'h00000012, err: 1'b0, acc: cyc + 1});
      @(posedge clk); #1;
      chk("next_accept", {31'h0, req_ready}, 32'd0);
      req_valid = 1'b0;
      drain();
    end

    // Reset while in RESP discards the response.
    do_req(1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0);
    rsp_ready = 1'b0;
    issue(0, 2'b10, 0, 32'h20, 32'h0, ok);
    if (ok) begin
      sb.push_back('{rdata: 32'hCAFEF00D, err: 1'b0, acc: cyc});
      req_valid = 1'b0;
      wait_valid("resp_valid_timeout");
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rstresp_valid", {31'h0, rsp_valid}, 32'd0);
      chk("rstresp_rdata", rsp_rdata, 32'h0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
    end

    // Reset one cycle after accepting a store aborts it.
    issue(1, 2'b10, 0, 32'h20, 32'h12345678, ok);
    if (ok) begin
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rstwait_valid", {31'h0, rsp_valid}, 32'd0);
      chk("rstwait_err", {31'h0, rsp_err}, 32'd0);
      chk("rstwait_ready", {31'h0, req_ready}, 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end
    do_req(0, 2'b10, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0);

    // Latency extremes on the side instances.
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_addr = 32'h0; req_wdata = 32'h01020304;
    x_valid = 1'b1;
    @(posedge clk); #1;
    x_valid = 1'b0;
    lat1 = -1; lat7 = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (v1 && lat1 < 0) lat1 = k;
      if (v7 && lat7 < 0) lat7 = k;
    end
    chk("latency_1", 32'(lat1), 32'd1);
    chk("latency_7", 32'(lat7), 32'd7);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
